mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request/response sequencer for the data-SRAM port. It sits between the EX stage, which issues loads and stores, and the MEM stage, which consumes load data, and drives a split-transaction SRAM-like bus (req/addr_ok, data_ok/rdata). It tracks outstanding transactions and buffers one response while MEM is stalled. On a pipeline flush (exception/ertn) it discards stale responses and neutralises any half-issued request.

## Interface
- MAX_OUTSTANDING, 2, max transactions accepted (addr_ok) but not yet answered (data_ok), plus the buffered response; legal range 1..3.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ex_req_valid  in  1  EX holds a valid memory instruction wanting to issue.
- ex_req_wr  in  1  1 = store.
- ex_req_size  in  2  0 byte, 1 half, 2 word.
- ex_req_wstrb  in  4  byte write enables.
- ex_req_addr  in  32  byte address.
- ex_req_wdata  in  32  store data.
- ex_req_ready  out  1  request accepted this cycle; EX may advance.
- data_sram_req  out  1  bus request.
- data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata  out  1/2/4/32/32  bus request fields.
- data_sram_addr_ok  in  1  request accepted by the bus.
- data_sram_data_ok  in  1  response returned, in order.
- data_sram_rdata  in  32  response data.
- mem_rdata  out  32  load data for MEM.
- mem_data_valid  out  1  mem_rdata holds the response for the instruction now in MEM.
- mem_data_ack  in  1  MEM consumed the response (instruction moves to WB).
- flush  in  1  pipeline flush; all in-flight memory work is dead.

## Operation
- Issue FSM states:
  - IDLE: bus fields are driven combinationally from ex_req_*.
  - WAIT: request issued, addr_ok not yet seen; bus fields are driven from the latch.
  - ORPHAN: flushed while in WAIT; the latched request is still driven, with wstrb forced to 4'b0000.
- Issue gate: can_issue = (out_cnt + rbuf_valid) < MAX_OUTSTANDING.
- IDLE:
  - data_sram_req = ex_req_valid & can_issue & ~flush.
  - addr_ok → stay IDLE, out_cnt++, ex_req_ready = 1.
  - No addr_ok → latch the fields, go to WAIT.
- WAIT:
  - req = 1 and fields stay stable until addr_ok.
  - addr_ok & ~flush → IDLE, out_cnt++, ex_req_ready = 1.
  - flush without addr_ok → ORPHAN.
  - flush with addr_ok → IDLE; the accepted request counts as cancelled.
- ORPHAN:
  - req = 1; ex_req_ready = 0.
  - addr_ok → IDLE; out_cnt++ and cancel_cnt++ (response will be dropped).
- out_cnt: +1 on addr_ok, −1 on data_ok; both in the same cycle leaves it unchanged.
- cancel_cnt:
  - On flush: cancel_cnt ← next value of out_cnt (all outstanding become cancelled).
  - On data_ok while cancel_cnt ≠ 0: the response is dropped and cancel_cnt−−.
- rbuf, one entry:
  - A non-cancelled data_ok writes rdata and sets rbuf_valid.
  - mem_data_ack clears rbuf_valid.
  - flush clears rbuf_valid.
- A data_ok arriving in the same cycle as flush is dropped.
- data_ok with rbuf full and no ack is a protocol error. The bench asserts it never happens.
- Counter widths: $clog2(MAX_OUTSTANDING+1). out_cnt never exceeds MAX_OUTSTANDING (assert).

## Timing
- All outputs are 0 after reset: state IDLE, out_cnt = cancel_cnt = 0, rbuf_valid = 0, mem_rdata = 0.
- Request: addr_ok in the same cycle as req gives zero-cycle acceptance (ex_req_ready combinational).
- Response: see Configuration; ordering is strictly in-order.
- resetn low mid-transaction: all state clears in one cycle. The bus is assumed reset together with the block.
- flush has priority over ex_req_valid in every state.

## Configuration
- MEM_REQ_CTRL_RDATA_BYPASS_EN defined:
  - mem_data_valid = rbuf_valid | (data_ok & cancel_cnt == 0 & ~flush).
  - mem_rdata = rbuf_valid ? rbuf : data_sram_rdata.
  - A bypassed response acked in the same cycle is not written to rbuf.
- Undefined:
  - The response is always registered.
  - mem_data_valid/mem_rdata come only from rbuf, one cycle after data_ok.

## Test plan
- Load addr 0x100, addr_ok same cycle, data_ok +2 with rdata 0xDEADBEEF, ack held 1:
  - Bypass: mem_data_valid in the data_ok cycle.
  - No bypass: mem_data_valid one cycle later.
  - mem_rdata = 0xDEADBEEF; out_cnt returns to 0.
- addr_ok withheld 3 cycles:
  - req and all fields stable, ex_req_ready = 0.
  - On the addr_ok cycle: ready = 1, state IDLE.
- Store pending in WAIT, then flush:
  - State ORPHAN; wstrb on the bus = 0000 until addr_ok.
  - Its data_ok is dropped; mem_data_valid stays 0.
- Two loads accepted (MAX = 2), flush, then a new load; three data_ok returning 0x1, 0x2, 0x3:
  - 0x1 and 0x2 are dropped.
  - Only 0x3 is presented.
- ack held 0 with rbuf full:
  - data_sram_req = 0 while out_cnt + rbuf_valid = 2.
  - Pulsing ack releases issue the next cycle.
- Simultaneous addr_ok and data_ok: out_cnt unchanged; resetn low mid-stream clears all counters and mem_data_valid.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Data-SRAM request/response sequencer between EX/MEM and a split-transaction bus.
// Optional MEM_REQ_CTRL_RDATA_BYPASS_EN forwards data_ok straight to MEM.
module mem_req_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_req_valid,
    input  logic        ex_req_wr,
    input  logic [1:0]  ex_req_size,
    input  logic [3:0]  ex_req_wstrb,
    input  logic [31:0] ex_req_addr,
    input  logic [31:0] ex_req_wdata,
    output logic        ex_req_ready,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] mem_rdata,
    output logic        mem_data_valid,
    input  logic        mem_data_ack,
    input  logic        flush
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ORPHAN = 2'd2} state_t;

    state_t         state, state_nxt;
    req_t           ex_fields, lat, bus;
    logic [CW-1:0]  out_cnt, out_cnt_nxt, cancel_cnt, cancel_cnt_nxt;
    logic           rbuf_valid;
    logic [31:0]    rbuf;
    logic           can_issue, acc, acc_orphan, latch_en;
    logic           drop, take, wr_rbuf;

    assign ex_fields = '{wr: ex_req_wr, size: ex_req_size, wstrb: ex_req_wstrb,
                         addr: ex_req_addr, wdata: ex_req_wdata};

    // The buffered response occupies a slot so a stalled MEM throttles issue.
    assign can_issue = ({1'b0, out_cnt} + (CW+1)'(rbuf_valid)) < (CW+1)'(MAX_OUTSTANDING);

    always_comb begin
        state_nxt     = state;
        bus           = ex_fields;
        data_sram_req = 1'b0;
        ex_req_ready  = 1'b0;
        acc           = 1'b0;
        acc_orphan    = 1'b0;
        latch_en      = 1'b0;
        case (state)
            IDLE: begin
                data_sram_req = ex_req_valid & can_issue & ~flush;
                if (data_sram_req) begin
                    if (data_sram_addr_ok) begin
                        acc          = 1'b1;
                        ex_req_ready = 1'b1;
                    end else begin
                        latch_en  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                bus           = lat;
                data_sram_req = 1'b1;
                if (data_sram_addr_ok) begin
                    acc          = 1'b1;
                    ex_req_ready = ~flush;
                    state_nxt    = IDLE;
                end else if (flush) begin
                    state_nxt = ORPHAN;
                end
            end
            ORPHAN: begin
                // Bus can't retract a request; finish it harmlessly with no byte enables.
                bus           = lat;
                bus.wstrb     = 4'b0000;
                data_sram_req = 1'b1;
                if (data_sram_addr_ok) begin
                    acc        = 1'b1;
                    acc_orphan = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data_sram_wr    = bus.wr;
    assign data_sram_size  = bus.size;
    assign data_sram_wstrb = bus.wstrb;
    assign data_sram_addr  = bus.addr;
    assign data_sram_wdata = bus.wdata;

    assign drop = data_sram_data_ok & (flush | (cancel_cnt != '0));
    assign take = data_sram_data_ok & ~drop;

    always_comb begin
        out_cnt_nxt = out_cnt + CW'(acc) - CW'(data_sram_data_ok);
        if (flush)
            cancel_cnt_nxt = out_cnt_nxt;
        else
            cancel_cnt_nxt = cancel_cnt + CW'(acc_orphan)
                           - CW'(data_sram_data_ok && (cancel_cnt != '0));
    end

`ifdef MEM_REQ_CTRL_RDATA_BYPASS_EN
    assign mem_data_valid = rbuf_valid | take;
    assign mem_rdata      = rbuf_valid ? rbuf : data_sram_rdata;
    // A bypassed response consumed on arrival never needs the buffer.
    assign wr_rbuf        = take & (rbuf_valid | ~mem_data_ack);
`else
    assign mem_data_valid = rbuf_valid;
    assign mem_rdata      = rbuf;
    assign wr_rbuf        = take;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            lat        <= '0;
            out_cnt    <= '0;
            cancel_cnt <= '0;
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
        end else begin
            state      <= state_nxt;
            out_cnt    <= out_cnt_nxt;
            cancel_cnt <= cancel_cnt_nxt;
            if (latch_en)
                lat <= ex_fields;
            if (flush) begin
                rbuf_valid <= 1'b0;
            end else if (wr_rbuf) begin
                rbuf_valid <= 1'b1;
                rbuf       <= data_sram_rdata;
            end else if (mem_data_ack) begin
                rbuf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl (MAX_OUTSTANDING = 2); expectations follow
// MEM_REQ_CTRL_RDATA_BYPASS_EN when defined.
module tb_mem_req_ctrl;
`ifdef MEM_REQ_CTRL_RDATA_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_req_valid, ex_req_wr;
    logic [1:0]  ex_req_size;
    logic [3:0]  ex_req_wstrb;
    logic [31:0] ex_req_addr, ex_req_wdata;
    logic        ex_req_ready;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] mem_rdata;
    logic        mem_data_valid, mem_data_ack, flush;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .ex_req_valid(ex_req_valid), .ex_req_wr(ex_req_wr), .ex_req_size(ex_req_size),
        .ex_req_wstrb(ex_req_wstrb), .ex_req_addr(ex_req_addr), .ex_req_wdata(ex_req_wdata),
        .ex_req_ready(ex_req_ready),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .mem_data_ack(mem_data_ack),
        .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic ex(input logic v, input logic wr, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] wdata);
        ex_req_valid = v;
        ex_req_wr    = wr;
        ex_req_size  = 2'd2;
        ex_req_wstrb = strb;
        ex_req_addr  = addr;
        ex_req_wdata = wdata;
    endtask

    task automatic bus_in(input logic aok, input logic dok, input logic [31:0] rd);
        data_sram_addr_ok = aok;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    // Continuous protocol monitors: occupancy bound and no response into a full, unacked buffer.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            assert (dut.out_cnt <= 2) else begin
                failures++;
                $error("FAIL out_cnt_bound observed=%0d expected<=2", dut.out_cnt);
            end
            checks++;
            assert (!(data_sram_data_ok && dut.rbuf_valid && !mem_data_ack &&
                      dut.cancel_cnt == 0 && !flush)) else begin
                failures++;
                $error("FAIL rbuf_overrun observed=1 expected=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        mem_data_ack = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'b0, data_sram_req}, 32'd0);
        chk("rst_ready", {31'b0, ex_req_ready}, 32'd0);
        chk("rst_valid", {31'b0, mem_data_valid}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_out_cnt", 32'(dut.out_cnt), 32'd0);
        chk("rst_cancel_cnt", 32'(dut.cancel_cnt), 32'd0);
        chk("rst_state", 32'(dut.state), 32'd0);
        resetn = 1'b1;
        tick();

        // Load 0x100, zero-cycle accept, data_ok two cycles later, ack held high.
        mem_data_ack = 1'b1;
        ex(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        settle();
        chk("ld_req", {31'b0, data_sram_req}, 32'd1);
        chk("ld_addr", data_sram_addr, 32'h100);
        chk("ld_ready", {31'b0, ex_req_ready}, 32'd1);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        chk("ld_out_cnt1", 32'(dut.out_cnt), 32'd1);
        tick();
        bus_in(1'b0, 1'b1, 32'hDEADBEEF);
        settle();
        chk("ld_valid_dok", {31'b0, mem_data_valid}, BYP ? 32'd1 : 32'd0);
        if (BYP) chk("ld_rdata_byp", mem_rdata, 32'hDEADBEEF);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        settle();
        chk("ld_valid_next", {31'b0, mem_data_valid}, BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("ld_rdata_reg", mem_rdata, 32'hDEADBEEF);
        chk("ld_out_cnt0", 32'(dut.out_cnt), 32'd0);
        tick();
        chk("ld_valid_clr", {31'b0, mem_data_valid}, 32'd0);

        // Store with addr_ok withheld 3 cycles; EX fields change but bus must hold.
        mem_data_ack = 1'b0;
        ex(1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678);
        settle();
        chk("wt_req0", {31'b0, data_sram_req}, 32'd1);
        chk("wt_ready0", {31'b0, ex_req_ready}, 32'd0);
        tick();
        ex(1'b1, 1'b0, 4'h1, 32'h204, 32'hFFFF0000);
        for (int i = 1; i < 3; i++) begin
            settle();
            chk("wt_state", 32'(dut.state), 32'd1);
            chk("wt_req", {31'b0, data_sram_req}, 32'd1);
            chk("wt_addr", data_sram_addr, 32'h200);
            chk("wt_fields", {data_sram_wr, data_sram_wstrb, data_sram_wdata[26:0]},
                {1'b1, 4'hF, 27'h2345678});
            chk("wt_ready", {31'b0, ex_req_ready}, 32'd0);
            tick();
        end
        bus_in(1'b1, 1'b0, 32'h0);
        settle();
        chk("wt_ready_aok", {31'b0, ex_req_ready}, 32'd1);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b1, 32'h0);
        mem_data_ack = 1'b1;
        chk("wt_state_idle", 32'(dut.state), 32'd0);
        chk("wt_out_cnt", 32'(dut.out_cnt), 32'd1);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        tick();
        chk("wt_out_cnt0", 32'(dut.out_cnt), 32'd0);

        // Store in WAIT, then flush: ORPHAN with wstrb forced off, response dropped.
        ex(1'b1, 1'b1, 4'b0011, 32'h300, 32'hAA55);
        settle();
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        flush = 1'b1;
        settle();
        chk("or_req_flush", {31'b0, data_sram_req}, 32'd1);
        chk("or_ready_flush", {31'b0, ex_req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        ex(1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
        settle();
        chk("or_state", 32'(dut.state), 32'd2);
        chk("or_wstrb", {28'b0, data_sram_wstrb}, 32'd0);
        chk("or_addr", data_sram_addr, 32'h300);
        chk("or_ready", {31'b0, ex_req_ready}, 32'd0);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        settle();
        chk("or_wstrb_aok", {28'b0, data_sram_wstrb}, 32'd0);
        chk("or_ready_aok", {31'b0, ex_req_ready}, 32'd0);
        tick();
        bus_in(1'b0, 1'b1, 32'h55);
        chk("or_cancel", 32'(dut.cancel_cnt), 32'd1);
        settle();
        chk("or_valid_dok", {31'b0, mem_data_valid}, 32'd0);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        settle();
        chk("or_valid_after", {31'b0, mem_data_valid}, 32'd0);
        chk("or_out_cnt", 32'(dut.out_cnt), 32'd0);
        tick();

        // Two loads, flush, new load; 0x1 and 0x2 dropped, 0x3 presented.
        ex(1'b1, 1'b0, 4'h0, 32'h500, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h504, 32'h0);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h508, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        settle();
        chk("fl_req_full", {31'b0, data_sram_req}, 32'd0);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cancel2", 32'(dut.cancel_cnt), 32'd2);
        bus_in(1'b0, 1'b1, 32'h1);
        settle();
        chk("fl_drop1", {31'b0, mem_data_valid}, 32'd0);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h600, 32'h0);
        bus_in(1'b1, 1'b1, 32'h2);
        settle();
        chk("fl_new_ready", {31'b0, ex_req_ready}, 32'd1);
        chk("fl_drop2", {31'b0, mem_data_valid}, 32'd0);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("sim_out_cnt", 32'(dut.out_cnt), 32'd1);
        bus_in(1'b0, 1'b1, 32'h3);
        settle();
        chk("fl_valid3_dok", {31'b0, mem_data_valid}, BYP ? 32'd1 : 32'd0);
        if (BYP) chk("fl_rdata3_byp", mem_rdata, 32'h3);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        settle();
        chk("fl_valid3_next", {31'b0, mem_data_valid}, BYP ? 32'd0 : 32'd1);
        if (!BYP) chk("fl_rdata3_reg", mem_rdata, 32'h3);
        tick();

        // ack held low with rbuf full throttles issue; an ack pulse releases it.
        mem_data_ack = 1'b0;
        ex(1'b1, 1'b0, 4'h0, 32'h700, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b1, 32'h77);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h704, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h708, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        mem_data_ack = 1'b1;
        settle();
        chk("bp_req_blocked", {31'b0, data_sram_req}, 32'd0);
        chk("bp_valid", {31'b0, mem_data_valid}, 32'd1);
        chk("bp_rdata", mem_rdata, 32'h77);
        tick();
        mem_data_ack = 1'b0;
        bus_in(1'b1, 1'b0, 32'h0);
        settle();
        chk("bp_req_release", {31'b0, data_sram_req}, 32'd1);
        chk("bp_ready", {31'b0, ex_req_ready}, 32'd1);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("bp_out_cnt2", 32'(dut.out_cnt), 32'd2);
        mem_data_ack = 1'b1;
        bus_in(1'b0, 1'b1, 32'h80);
        tick();
        bus_in(1'b0, 1'b1, 32'h81);
        settle();
        chk("bp_rdata81", mem_rdata, BYP ? 32'h81 : 32'h80);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        tick();
        chk("bp_out_cnt0", 32'(dut.out_cnt), 32'd0);
        chk("bp_valid0", {31'b0, mem_data_valid}, 32'd0);

        // Reset mid-stream with cancellations pending and a request in WAIT.
        ex(1'b1, 1'b0, 4'h0, 32'h800, 32'h0);
        bus_in(1'b1, 1'b0, 32'h0);
        tick();
        ex(1'b1, 1'b0, 4'h0, 32'h804, 32'h0);
        tick();
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_in(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus_in(1'b0, 1'b1, 32'h98);
        tick();
        bus_in(1'b0, 1'b0, 32'h0);
        ex(1'b1, 1'b0, 4'h0, 32'h808, 32'h0);
        tick();
        chk("rs_pre_state", 32'(dut.state), 32'd1);
        chk("rs_pre_cancel", 32'(dut.cancel_cnt), 32'd1);
        ex(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        tick();
        chk("rs_state", 32'(dut.state), 32'd0);
        chk("rs_out_cnt", 32'(dut.out_cnt), 32'd0);
        chk("rs_cancel", 32'(dut.cancel_cnt), 32'd0);
        chk("rs_valid", {31'b0, mem_data_valid}, 32'd0);
        chk("rs_req", {31'b0, data_sram_req}, 32'd0);
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
